// File: rtl/pipe_tx_packer_if.sv
// Word stream from the per-lane scramblers into pipe_tx_packer.
// Lanes are concatenated with lane 0 in the LSBs. Transfer uses a valid/ready handshake.
interface pipe_tx_packer_if #(
  parameter int LANES = 4
);
  logic [LANES*32-1:0] in_data;
  logic [LANES*4-1:0]  in_k;
  logic [LANES*2-1:0]  in_sync_header;
  logic                in_block_start;
  logic                in_valid;
  logic                in_ready;

  modport master (
    output in_data, in_k, in_sync_header, in_block_start, in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data, in_k, in_sync_header, in_block_start, in_valid,
    output in_ready
  );
endinterface

// File: rtl/pipe_tx_packer.sv
// Multi-lane PIPE TX formatter. It serialises 32-bit lane words to the generation width.
// For Gen3 and above it also tracks 128b/130b block boundaries and inserts the gearbox stall.
module pipe_tx_packer #(
  parameter int LANES        = 4,
  parameter int PW_GEN1      = 8,
  parameter int PW_GEN2      = 8,
  parameter int PW_GEN3      = 16,
  parameter int PW_GEN4      = 32,
  parameter int PW_GEN5      = 32,
  parameter int STALL_BLOCKS = 8
) (
  input  logic                 pclk,
  input  logic                 reset_n,
  input  logic [2:0]           generation,
  pipe_tx_packer_if.slave      in_if,
  output logic [LANES*32-1:0]  TxData,
  output logic [LANES*4-1:0]   TxDataK,
  output logic                 TxDataValid,
  output logic                 TxStartBlock,
  output logic [LANES*2-1:0]   TxSyncHeader,
  output logic                 align_err
);

  localparam int BCW = (STALL_BLOCKS > 1) ? $clog2(STALL_BLOCKS) : 1;
  localparam logic [BCW-1:0] LAST_BLK = BCW'((STALL_BLOCKS > 0) ? STALL_BLOCKS - 1 : 0);

  function automatic logic supported(input logic [2:0] g);
    return (g >= 3'd1) && (g <= 3'd5);
  endfunction

  function automatic int unsigned width_of(input logic [2:0] g);
    case (g)
      3'd1:    return PW_GEN1;
      3'd2:    return PW_GEN2;
      3'd3:    return PW_GEN3;
      3'd4:    return PW_GEN4;
      3'd5:    return PW_GEN5;
      default: return 32;
    endcase
  endfunction

  // Control state
  logic [2:0]          gen_q;
  logic                full_q;
  logic                stall_q;
  logic                hold_bs_q;
  logic                align_q;
  logic [1:0]          beat_q;
  logic [3:0]          byte_cnt_q;   // block position of the current beat (or of the next one when idle)
  logic [BCW-1:0]      block_cnt_q;
  logic [LANES*2-1:0]  sh_q;

  // Word buffer
  logic [LANES*32-1:0] hold_data_q;
  logic [LANES*4-1:0]  hold_k_q;
  logic [LANES*2-1:0]  hold_sh_q;

  int unsigned w;
  logic [1:0]  last_beat;
  logic [3:0]  step;
  logic [3:0]  pos_after;
  logic [31:0] data_mask;
  logic [3:0]  k_mask;
  logic        sup, gen3p, flush, valid_now, wrap, stall_next, word_done, accept;

  always_comb begin
    // NOTE: every combinational signal is given a default first so that no path infers a latch.
    w          = width_of(gen_q);
    last_beat  = 2'(32 / w - 1);
    step       = 4'(w / 8);
    data_mask  = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    k_mask     = 4'((32'd1 << (w / 8)) - 32'd1);
    sup        = supported(gen_q);
    gen3p      = sup && (gen_q >= 3'd3);
    flush      = (generation != gen_q) || !sup;
    valid_now  = full_q && !stall_q;
    pos_after  = (valid_now && gen3p) ? byte_cnt_q + step : byte_cnt_q;
    wrap       = valid_now && gen3p && (pos_after == 4'd0);
    stall_next = wrap && (STALL_BLOCKS > 0) && (block_cnt_q == LAST_BLK);
    word_done  = valid_now && (beat_q == last_beat);

    // Ready depends on registered state only.
    in_if.in_ready = sup && !stall_q && (!full_q || ((beat_q == last_beat) && !stall_next));
    accept         = in_if.in_valid && in_if.in_ready;

    TxData  = '0;
    TxDataK = '0;
    for (int l = 0; l < LANES; l++) begin
      if (valid_now) begin
        TxData[l*32 +: 32] = (hold_data_q[l*32 +: 32] >> (32'(beat_q) * w)) & data_mask;
        if (!gen3p)
          TxDataK[l*4 +: 4] = (hold_k_q[l*4 +: 4] >> (32'(beat_q) * (w / 8))) & k_mask;
      end
    end

    TxDataValid  = valid_now;
    TxStartBlock = valid_now && gen3p && (byte_cnt_q == 4'd0);
    // A block opened without in_block_start keeps the previous header.
    TxSyncHeader = (TxStartBlock && hold_bs_q) ? hold_sh_q : sh_q;
    align_err    = align_q;
  end

  // NOTE: state registers use non-blocking assignments, so each one samples its pre-edge value.
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      gen_q       <= '0;
      full_q      <= 1'b0;
      stall_q     <= 1'b0;
      hold_bs_q   <= 1'b0;
      align_q     <= 1'b0;
      beat_q      <= '0;
      byte_cnt_q  <= '0;
      block_cnt_q <= '0;
      sh_q        <= '0;
    end else begin
      gen_q   <= generation;
      align_q <= 1'b0;
      if (flush) begin
        full_q      <= 1'b0;
        stall_q     <= 1'b0;
        hold_bs_q   <= 1'b0;
        beat_q      <= '0;
        byte_cnt_q  <= '0;
        block_cnt_q <= '0;
        sh_q        <= '0;
      end else if (stall_q) begin
        stall_q <= 1'b0;
      end else begin
        sh_q <= TxSyncHeader;
        if (valid_now)
          byte_cnt_q <= pos_after;
        if (wrap && (STALL_BLOCKS > 0)) begin
          if (stall_next) begin
            block_cnt_q <= '0;
            stall_q     <= 1'b1;
          end else begin
            block_cnt_q <= block_cnt_q + 1'b1;
          end
        end
        if (accept) begin
          full_q    <= 1'b1;
          beat_q    <= '0;
          hold_bs_q <= in_if.in_block_start;
          if (gen3p) begin
            align_q <= in_if.in_block_start ? (pos_after != 4'd0) : (pos_after == 4'd0);
            if (in_if.in_block_start)
              byte_cnt_q <= '0;
          end
        end else if (word_done) begin
          full_q <= 1'b0;
        end else if (valid_now) begin
          beat_q <= beat_q + 2'd1;
        end
      end
    end
  end

  // NOTE: the word buffer has no reset; full_q qualifies every use of it.
  always_ff @(posedge pclk) begin
    if (accept) begin
      hold_data_q <= in_if.in_data;
      hold_k_q    <= in_if.in_k;
      hold_sh_q   <= in_if.in_sync_header;
    end
  end

endmodule
